// File: rtl/hartslag_bewaking_if.sv
// Sample/average bus between the heart-rate counter stage and the monitor.
// The master publishes window counts; the slave (the monitor) reports average and alarm state.
interface hartslag_bewaking_if;
    logic [7:0] slagen_in;
    logic       slagen_valid;
    logic [7:0] gemiddelde;
    logic       gem_valid;
    logic       gem_strobe;
    logic [1:0] status;
    logic       alarm_laag;
    logic       alarm_hoog;

    modport master (
        output slagen_in, slagen_valid,
        input  gemiddelde, gem_valid, gem_strobe, status, alarm_laag, alarm_hoog
    );

    modport slave (
        input  slagen_in, slagen_valid,
        output gemiddelde, gem_valid, gem_strobe, status, alarm_laag, alarm_hoog
    );
endinterface

// File: rtl/hartslag_bewaking.sv
// Sliding average of beats-per-window over 2^DEPTH_LOG2 windows.
// A hysteretic low/high alarm FSM is driven by each published average.
module hartslag_bewaking #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned LOW_TH     = 10,
    parameter int unsigned HIGH_TH    = 40,
    parameter int unsigned HYST       = 2,
    parameter int unsigned CONFIRM    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    hartslag_bewaking_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned SW    = 8 + DEPTH_LOG2;

    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_NORMAAL = 2'd1;
    localparam logic [1:0] ST_LAAG    = 2'd2;
    localparam logic [1:0] ST_HOOG    = 2'd3;

    localparam logic [7:0] LOW_B       = 8'(LOW_TH);
    localparam logic [7:0] HIGH_B      = 8'(HIGH_TH);
    localparam logic [7:0] LOW_LEAVE   = 8'(LOW_TH + HYST);
    localparam logic [7:0] HIGH_LEAVE  = 8'(HIGH_TH - HYST);
    localparam logic [3:0] CONFIRM_B   = 4'(CONFIRM);

    localparam logic [DEPTH_LOG2:0] FILL_LAST = (DEPTH_LOG2 + 1)'(DEPTH - 1);
    localparam logic [DEPTH_LOG2:0] FILL_MAX  = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            hist_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q;
    logic [SW-1:0]         sum_q;
    logic [SW-1:0]         sum_d;
    logic [DEPTH_LOG2:0]   fill_q;
    logic [7:0]            gem_q;
    logic                  gem_valid_q;
    logic                  gem_strobe_q;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  dir_hoog_q, dir_hoog_d;
    logic [3:0]            cnt_run;

    // Oldest entry sits at the write pointer, so it is subtracted before being overwritten.
    always_comb begin
        sum_d = sum_q + SW'(bus.slagen_in) - SW'(hist_q[wptr_q]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            wptr_q       <= '0;
            sum_q        <= '0;
            fill_q       <= '0;
            gem_q        <= '0;
            gem_valid_q  <= 1'b0;
            gem_strobe_q <= 1'b0;
        end else begin
            gem_strobe_q <= 1'b0;
            if (bus.slagen_valid) begin
                hist_q[wptr_q] <= bus.slagen_in;
                wptr_q         <= wptr_q + 1'b1;
                sum_q          <= sum_d;
                gem_q          <= sum_d[SW-1:DEPTH_LOG2];
                if (fill_q != FILL_MAX) begin
                    fill_q <= fill_q + 1'b1;
                end
                if (fill_q >= FILL_LAST) begin
                    gem_valid_q  <= 1'b1;
                    gem_strobe_q <= 1'b1;
                end
            end
        end
    end

    // cnt_q counts consecutive out-of-range averages in direction dir_hoog_q; 0 means no run.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dir_hoog_d = dir_hoog_q;
        cnt_run    = '0;
        if (gem_strobe_q) begin
            case (state_q)
                ST_INIT: begin
                    state_d = ST_NORMAAL;
                    cnt_d   = '0;
                end
                ST_NORMAAL: begin
                    if (gem_q < LOW_B) begin
                        cnt_run    = (!dir_hoog_q && cnt_q != '0) ? cnt_q + 4'd1 : 4'd1;
                        dir_hoog_d = 1'b0;
                        if (cnt_run >= CONFIRM_B) begin
                            state_d = ST_LAAG;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_run;
                        end
                    end else if (gem_q > HIGH_B) begin
                        cnt_run    = (dir_hoog_q && cnt_q != '0) ? cnt_q + 4'd1 : 4'd1;
                        dir_hoog_d = 1'b1;
                        if (cnt_run >= CONFIRM_B) begin
                            state_d = ST_HOOG;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_run;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                ST_LAAG: begin
                    if (gem_q >= LOW_LEAVE) begin
                        state_d = ST_NORMAAL;
                    end
                end
                default: begin
                    if (gem_q <= HIGH_LEAVE) begin
                        state_d = ST_NORMAAL;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            dir_hoog_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dir_hoog_q <= dir_hoog_d;
        end
    end

    assign bus.gemiddelde = gem_q;
    assign bus.gem_valid  = gem_valid_q;
    assign bus.gem_strobe = gem_strobe_q;
    assign bus.status     = state_q;
    assign bus.alarm_laag = (state_q == ST_LAAG);
    assign bus.alarm_hoog = (state_q == ST_HOOG);
endmodule

// File: tb/tb_hartslag_bewaking.sv
// Bench for hartslag_bewaking: directed scenarios with literal expectations,
// then random traffic, all checked every cycle against a sample-history model.
module tb_hartslag_bewaking;
    localparam int DEPTH   = 4;
    localparam int LOW_TH  = 10;
    localparam int HIGH_TH = 40;
    localparam int HYST    = 2;
    localparam int CONFIRM = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    hartslag_bewaking_if bus ();

    hartslag_bewaking #(
        .DEPTH_LOG2 (2),
        .LOW_TH     (LOW_TH),
        .HIGH_TH    (HIGH_TH),
        .HYST       (HYST),
        .CONFIRM    (CONFIRM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: keeps the last DEPTH samples and a signed streak (negative = low run).
    int q_hist[$];
    int m_count  = 0;
    int m_avg    = 0;
    int m_valid  = 0;
    int m_strobe = 0;
    int m_state  = 0;
    int m_streak = 0;

    always @(posedge clk) begin
        if (reset) begin
            q_hist.delete();
            m_count = 0; m_avg = 0; m_valid = 0; m_strobe = 0;
            m_state = 0; m_streak = 0;
        end else begin
            if (m_strobe != 0) begin
                case (m_state)
                    0: m_state = 1;
                    1: begin
                        if (m_avg < LOW_TH) begin
                            m_streak = (m_streak < 0) ? m_streak - 1 : -1;
                            if (-m_streak >= CONFIRM) begin m_state = 2; m_streak = 0; end
                        end else if (m_avg > HIGH_TH) begin
                            m_streak = (m_streak > 0) ? m_streak + 1 : 1;
                            if (m_streak >= CONFIRM) begin m_state = 3; m_streak = 0; end
                        end else begin
                            m_streak = 0;
                        end
                    end
                    2: if (m_avg >= LOW_TH + HYST) m_state = 1;
                    default: if (m_avg <= HIGH_TH - HYST) m_state = 1;
                endcase
            end
            m_strobe = 0;
            if (bus.slagen_valid) begin
                int s;
                q_hist.push_back(int'(bus.slagen_in));
                if (q_hist.size() > DEPTH) void'(q_hist.pop_front());
                s = 0;
                foreach (q_hist[i]) s += q_hist[i];
                m_avg = s / DEPTH;
                if (m_count < DEPTH) m_count++;
                if (m_count == DEPTH) begin m_valid = 1; m_strobe = 1; end
            end
        end
    end

    always @(negedge clk) begin
        check("gemiddelde", int'(bus.gemiddelde), m_avg);
        check("gem_valid",  int'(bus.gem_valid),  m_valid);
        check("gem_strobe", int'(bus.gem_strobe), m_strobe);
        check("status",     int'(bus.status),     m_state);
        check("alarm_laag", int'(bus.alarm_laag), (m_state == 2) ? 1 : 0);
        check("alarm_hoog", int'(bus.alarm_hoog), (m_state == 3) ? 1 : 0);
    end

    // Returns at the negedge where the average of this sample is visible.
    task automatic feed(input int v);
        @(negedge clk);
        bus.slagen_in    = 8'(v);
        bus.slagen_valid = 1'b1;
        @(negedge clk);
        bus.slagen_valid = 1'b0;
    endtask

    task automatic step(input int v, input int exp_avg, input int exp_status);
        feed(v);
        check("d_avg", int'(bus.gemiddelde), exp_avg);
        @(negedge clk);
        check("d_status", int'(bus.status), exp_status);
        check("d_alarm_laag", int'(bus.alarm_laag), (exp_status == 2) ? 1 : 0);
        check("d_alarm_hoog", int'(bus.alarm_hoog), (exp_status == 3) ? 1 : 0);
    endtask

    int regime;
    int v;

    initial begin
        bus.slagen_in    = '0;
        bus.slagen_valid = 1'b0;
        reset            = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_avg",    int'(bus.gemiddelde), 0);
        check("rst_valid",  int'(bus.gem_valid),  0);
        check("rst_status", int'(bus.status),     0);
        reset = 1'b0;

        // Fill phase and first published average
        repeat (3) feed(20);
        check("fill_valid",  int'(bus.gem_valid), 0);
        check("fill_status", int'(bus.status),    0);
        feed(20);
        check("first_avg",    int'(bus.gemiddelde), 20);
        check("first_valid",  int'(bus.gem_valid),  1);
        check("first_strobe", int'(bus.gem_strobe), 1);
        @(negedge clk);
        check("first_status", int'(bus.status), 1);
        check("strobe_once",  int'(bus.gem_strobe), 0);

        // Sliding average down to the LOW_TH boundary (in range)
        step(40, 25, 1); step(0, 20, 1); step(0, 15, 1); step(0, 10, 1);

        // Back to steady 20, then confirmed low alarm and hysteretic exit
        step(20, 5, 1); step(20, 10, 1); step(20, 15, 1); step(20, 20, 1);
        step(4, 16, 1); step(4, 12, 1); step(4, 8, 1); step(4, 4, 2);
        step(30, 10, 2); step(30, 17, 1);

        // Steady 40 (HIGH_TH boundary in range), confirmed high alarm, exit
        step(40, 26, 1); step(40, 35, 1); step(40, 37, 1); step(40, 40, 1);
        step(41, 40, 1); step(41, 40, 1); step(41, 40, 1); step(41, 41, 1);
        step(41, 41, 3);
        step(38, 40, 3); step(38, 39, 3); step(38, 38, 1);

        // Direction switch restarts the run at 1: low, high (no alarm), high -> HOOG
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        feed(0); feed(0); feed(0); feed(36);
        check("dir_first_avg", int'(bus.gemiddelde), 9);
        step(0, 9, 1); step(128, 41, 1); step(0, 41, 3);

        // Reset wins over a same-cycle sample while in HOOG
        @(negedge clk);
        reset = 1'b1; bus.slagen_valid = 1'b1; bus.slagen_in = 8'd200;
        @(negedge clk);
        reset = 1'b0; bus.slagen_valid = 1'b0;
        check("mid_rst_avg",    int'(bus.gemiddelde), 0);
        check("mid_rst_valid",  int'(bus.gem_valid),  0);
        check("mid_rst_strobe", int'(bus.gem_strobe), 0);
        check("mid_rst_status", int'(bus.status),     0);
        check("mid_rst_hoog",   int'(bus.alarm_hoog), 0);
        feed(50); feed(50); feed(50);
        check("refill_valid_3", int'(bus.gem_valid), 0);
        feed(50);
        check("refill_valid_4", int'(bus.gem_valid), 1);
        check("refill_avg",     int'(bus.gemiddelde), 50);

        // Random traffic in regimes that push the average low, mid and high
        regime = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (c % 40 == 0) regime = int'($urandom_range(0, 3));
            case (regime)
                0: v = int'($urandom_range(0, 12));
                1: v = int'($urandom_range(12, 38));
                2: v = int'($urandom_range(38, 70));
                default: v = int'($urandom_range(0, 255));
            endcase
            bus.slagen_in    = 8'(v);
            bus.slagen_valid = ($urandom_range(0, 2) != 0);
            reset            = ($urandom_range(0, 399) == 0);
        end
        @(negedge clk);
        bus.slagen_valid = 1'b0;
        reset            = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
